// File: rtl/temp_ctrl_pkg.sv
// Shared types for the per-zone hysteresis temperature controller:
// FSM state encoding, operating modes and fault codes.
package temp_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    HEATING = 3'b001,
    COOLING = 3'b010,
    LOCKOUT = 3'b011,
    FAULT   = 3'b100
  } state_e;

  typedef enum logic [1:0] {
    OFF       = 2'b00,
    HEAT_ONLY = 2'b01,
    COOL_ONLY = 2'b10,
    AUTO      = 2'b11
  } mode_e;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_RANGE = 2'b01;
  localparam logic [1:0] FC_STALE = 2'b10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/temp_ctrl_thresh.sv
// Saturating hysteresis band: lo = max(set - tol, 0), hi = min(set + tol, all-ones),
// computed one bit wider than the temperature so borrow/carry are visible.
module temp_ctrl_thresh #(
  parameter int TEMP_W = 8,
  parameter int TOL_W  = 5
) (
  input  logic [TEMP_W-1:0] desired_i,
  input  logic [TOL_W-1:0]  tol_i,
  output logic [TEMP_W-1:0] lo_o,
  output logic [TEMP_W-1:0] hi_o
);

  localparam int XW = TEMP_W + 1;

  logic [XW-1:0]     d_x;
  logic [XW-1:0]     t_x;
  logic [XW-1:0]     sum;
  logic [TEMP_W-1:0] diff;

  assign d_x  = {1'b0, desired_i};
  assign t_x  = XW'(tol_i);
  assign sum  = d_x + t_x;
  assign diff = desired_i - t_x[TEMP_W-1:0];

  assign lo_o = (t_x > d_x) ? '0 : diff;
  assign hi_o = sum[TEMP_W] ? '1 : sum[TEMP_W-1:0];

endmodule

// File: rtl/temp_ctrl_hyst.sv
// Single-zone heater/cooler hysteresis controller with min on-time, lockout and
// range fault. Optional stale-sample watchdog: define TEMP_CTRL_WATCHDOG_EN.
module temp_ctrl_hyst
  import temp_ctrl_pkg::*;
#(
  parameter int TEMP_W      = 8,
  parameter int TOL_W       = 5,
  parameter int MIN_ON_CYC  = 16,
  parameter int MIN_OFF_CYC = 16,
  parameter int T_MIN       = 0,
  parameter int T_MAX       = 2**TEMP_W - 1,
  parameter int WDOG_CYC    = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [TEMP_W-1:0] temp_in,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] desired_temp,
  input  logic [TOL_W-1:0]  temp_tolerance,
  input  logic [1:0]        mode,
  input  logic              fault_clr,
  output logic              heater_on,
  output logic              cooler_on,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [2:0]        state_o
);

  localparam int DW = $clog2(max_int(MIN_ON_CYC, MIN_OFF_CYC) + 1);
  localparam logic [DW-1:0] ON_LAST  = DW'(MIN_ON_CYC - 1);
  localparam logic [DW-1:0] OFF_LAST = DW'(MIN_OFF_CYC - 1);

  state_e            state_q, state_d;
  logic [1:0]        fault_code_q, fault_code_d;
  logic [TEMP_W-1:0] temp_q;
  logic              have_sample_q;
  logic [DW-1:0]     dwell_q;
  logic [TEMP_W-1:0] lo, hi;
  mode_e             mode_m;
  logic              heat_ok, cool_ok;
  logic              in_lo_bad, in_hi_bad, q_lo_bad, q_hi_bad;
  logic              range_err, temp_q_ok, stale;

  temp_ctrl_thresh #(
    .TEMP_W (TEMP_W),
    .TOL_W  (TOL_W)
  ) u_thresh (
    .desired_i (desired_temp),
    .tol_i     (temp_tolerance),
    .lo_o      (lo),
    .hi_o      (hi)
  );

  // Bounds that cover the whole code space are dropped rather than compared.
  if (T_MIN > 0) begin : g_lo_chk
    assign in_lo_bad = temp_in < TEMP_W'(T_MIN);
    assign q_lo_bad  = temp_q  < TEMP_W'(T_MIN);
  end else begin : g_lo_none
    assign in_lo_bad = 1'b0;
    assign q_lo_bad  = 1'b0;
  end

  if (T_MAX < 2**TEMP_W - 1) begin : g_hi_chk
    assign in_hi_bad = temp_in > TEMP_W'(T_MAX);
    assign q_hi_bad  = temp_q  > TEMP_W'(T_MAX);
  end else begin : g_hi_none
    assign in_hi_bad = 1'b0;
    assign q_hi_bad  = 1'b0;
  end

  assign range_err = temp_valid && (in_lo_bad || in_hi_bad);
  assign temp_q_ok = !(q_lo_bad || q_hi_bad);

`ifdef TEMP_CTRL_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYC + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYC - 1);

  logic [WW-1:0] wdog_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q <= '0;
    end else if (temp_valid) begin
      wdog_q <= '0;
    end else if (wdog_q != WDOG_LAST) begin
      wdog_q <= wdog_q + 1'b1;
    end
  end

  assign stale = have_sample_q && (wdog_q == WDOG_LAST) && !temp_valid;
`else
  assign stale = 1'b0;
  if (WDOG_CYC < 1) begin : g_wdog_param_unused
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      temp_q        <= '0;
      have_sample_q <= 1'b0;
    end else if (temp_valid) begin
      temp_q        <= temp_in;
      have_sample_q <= 1'b1;
    end
  end

  assign mode_m  = mode_e'(mode);
  assign heat_ok = (mode_m == HEAT_ONLY) || (mode_m == AUTO);
  assign cool_ok = (mode_m == COOL_ONLY) || (mode_m == AUTO);

  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    if (range_err) begin
      state_d      = FAULT;
      fault_code_d = FC_RANGE;
    end else if (stale) begin
      state_d      = FAULT;
      fault_code_d = FC_STALE;
    end else begin
      case (state_q)
        IDLE: begin
          if (have_sample_q && mode_m != OFF) begin
            if (temp_q < lo && heat_ok)      state_d = HEATING;
            else if (temp_q > hi && cool_ok) state_d = COOLING;
          end
        end
        HEATING: begin
          if (!heat_ok)                                         state_d = LOCKOUT;
          else if (temp_q >= desired_temp && dwell_q >= ON_LAST) state_d = LOCKOUT;
        end
        COOLING: begin
          if (!cool_ok)                                         state_d = LOCKOUT;
          else if (temp_q <= desired_temp && dwell_q >= ON_LAST) state_d = LOCKOUT;
        end
        LOCKOUT: begin
          if (dwell_q >= OFF_LAST) state_d = IDLE;
        end
        FAULT: begin
          if (fault_clr && temp_q_ok) begin
            state_d      = LOCKOUT;
            fault_code_d = FC_NONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      fault_code_q <= FC_NONE;
      dwell_q      <= '0;
    end else begin
      state_q      <= state_d;
      fault_code_q <= fault_code_d;
      if (state_d != state_q)  dwell_q <= '0;
      else if (dwell_q != '1)  dwell_q <= dwell_q + 1'b1;
    end
  end

  assign heater_on  = (state_q == HEATING);
  assign cooler_on  = (state_q == COOLING);
  assign fault      = (state_q == FAULT);
  assign fault_code = fault_code_q;
  assign state_o    = state_q;

endmodule

// File: doc/temp_ctrl_hyst.md
Name: temp_ctrl_hyst

Overview:
- Parametrised successor to the single-zone heater/cooler FSM, with configurable temperature width.
- Adds an operating-mode select, a minimum actuator on-time, a post-actuation lockout (minimum off-time), sensor range-fault detection and a sample-valid input handshake.
- Sits between the sensor sampling front-end and the heater/cooler drivers.
- One instance per zone.

Parameters:
- TEMP_W, 8: width of temperature and setpoint values (unsigned).
- TOL_W, 5: width of the tolerance input.
- MIN_ON_CYC, 16: minimum cycles HEATING or COOLING is held before a normal exit (≥1).
- MIN_OFF_CYC, 16: cycles spent in LOCKOUT after any actuator turns off (≥1).
- T_MIN, 0: lowest valid sensor reading.
- T_MAX, 2**TEMP_W-1: highest valid sensor reading.
- WDOG_CYC, 1024: stale-sample timeout in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- temp_in  in  TEMP_W  sensor reading; sampled only when temp_valid=1.
- temp_valid  in  1  single-cycle qualifier for temp_in.
- desired_temp  in  TEMP_W  setpoint; used live every cycle.
- temp_tolerance  in  TOL_W  hysteresis half-band.
- mode  in  2  00 OFF, 01 HEAT_ONLY, 10 COOL_ONLY, 11 AUTO.
- fault_clr  in  1  pulse that requests exit from FAULT.
- heater_on  out  1  heater drive.
- cooler_on  out  1  cooler drive.
- fault  out  1  high while in FAULT.
- fault_code  out  2  00 none, 01 out-of-range, 10 stale sample.
- state_o  out  3  current FSM state, for status/debug.

Behaviour:
- Reset (reset_n=0, async): state=IDLE, temp_q=0, have_sample=0, dwell_cnt=0, fault_code=00. All outputs 0.
- Sample capture: on a clk edge with temp_valid=1, temp_q<=temp_in and have_sample<=1. The FSM evaluates temp_q every cycle, never temp_in directly.
- Thresholds are computed in TEMP_W+1 bits:
  - lo = max(desired_temp - temp_tolerance, 0), saturating.
  - hi = min(desired_temp + temp_tolerance, 2**TEMP_W-1), saturating.
- Range check: on a valid sample with temp_in<T_MIN or temp_in>T_MAX, the next state is FAULT with fault_code=01. This check has highest priority from every state.
- States and encoding: IDLE=000, HEATING=001, COOLING=010, LOCKOUT=011, FAULT=100.
- IDLE:
  - Stays in IDLE while have_sample=0 or mode=OFF.
  - temp_q<lo and mode is HEAT_ONLY or AUTO -> HEATING.
  - Otherwise, temp_q>hi and mode is COOL_ONLY or AUTO -> COOLING.
- HEATING:
  - mode changes to OFF or COOL_ONLY -> LOCKOUT immediately; this overrides the minimum on-time.
  - Otherwise, temp_q>=desired_temp and dwell_cnt>=MIN_ON_CYC-1 -> LOCKOUT.
- COOLING: mirror of HEATING. Exit condition is temp_q<=desired_temp; disallowing modes are OFF and HEAT_ONLY.
- LOCKOUT: exits to IDLE once dwell_cnt>=MIN_OFF_CYC-1. Heating/cooling requests are ignored while in LOCKOUT.
- FAULT:
  - Both actuators are off.
  - fault_clr=1 with the last sample in range (and no out-of-range valid sample in the same cycle) -> LOCKOUT, and fault_code clears to 00.
  - An out-of-range sample arriving in the same cycle as fault_clr keeps the FSM in FAULT.
- dwell_cnt: cleared to 0 on every state change, otherwise incremented each cycle. It saturates at its maximum and is wide enough for max(MIN_ON_CYC, MIN_OFF_CYC).
- Outputs are Moore decodes of the state register:
  - heater_on = (state==HEATING), cooler_on = (state==COOLING), fault = (state==FAULT).
  - A qualifying sample at edge k produces the output change visible after edge k+1: one cycle for capture, one for the state update.
- heater_on and cooler_on are never high simultaneously.
- Every actuator-off event is followed by exactly MIN_OFF_CYC cycles of LOCKOUT. A direct HEATING<->COOLING transition is impossible.
- Reset asserted mid-operation drops both actuators asynchronously. No lockout is enforced after reset.

Optional Feature:
- Macro: TEMP_CTRL_WATCHDOG_EN.
- When defined:
  - A counter clears on every temp_valid and increments otherwise, saturating.
  - When the counter reaches WDOG_CYC-1 while have_sample=1, the next state is FAULT with fault_code=10.
  - Recovery is identical to range fault: the watchdog condition must be cleared by a fresh valid sample before fault_clr is honoured.
- When undefined: no counter, and fault_code=10 never occurs.

Decomposition:
- Package temp_ctrl_pkg holds:
  - the state enum type (IDLE, HEATING, COOLING, LOCKOUT, FAULT);
  - the mode enum (OFF, HEAT_ONLY, COOL_ONLY, AUTO);
  - fault_code localparams.
- Sub-module temp_ctrl_thresh: combinational saturating lo/hi computation, parametrised by TEMP_W and TOL_W.
- The FSM, dwell counter and watchdog remain in the top module.

Test Plan:
- AUTO, desired=50, tol=5, sample 40 -> heater_on=1 two cycles after the sample. Then sample 50 at dwell 3 with MIN_ON_CYC=16 -> heater holds until dwell reaches 15, then LOCKOUT for 16 cycles, then IDLE.
- AUTO, desired=50, tol=5, sample 60 -> cooler_on=1. Then sample 49 -> LOCKOUT. A sample of 30 during LOCKOUT -> no heater until IDLE, then HEATING.
- Saturation: desired=3, tol=10, sample 0 -> lo=0, stays IDLE. desired=250, tol=10, sample 255 -> hi=255, stays IDLE.
- HEATING at dwell 2, mode switched to COOL_ONLY -> heater_on=0 next cycle, state_o=LOCKOUT.
- T_MIN=10, T_MAX=200, sample 5 -> fault=1, fault_code=01, outputs 0. fault_clr with the same stale out-of-range sample -> stays FAULT. Sample 60, then fault_clr -> LOCKOUT.
- reset_n pulsed low while cooler_on=1 -> cooler_on=0 asynchronously, state_o=000, fault_code=00. With TEMP_CTRL_WATCHDOG_EN and WDOG_CYC=64, no samples for 64 cycles -> FAULT with fault_code=10.
